// File: rtl/fft_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module : fft_frame_buffer
// Desc   : Double-buffered collector that groups the serial sample stream into
//          N-sample frames for fft_256 and issues fft_start per full frame.
//          Optional macro FRAME_DROP_EN: drop frames while the FFT is busy
//          instead of applying backpressure.
// Rev    : 1.0
// ============================================================================
module fft_frame_buffer #(
    parameter int WIDTH = 12,
    parameter int N     = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     sample_in,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    // element k lives at [k*WIDTH +: WIDTH]; element 0 is the oldest sample
    output logic [N*WIDTH-1:0]   time_samples,
    output logic                 fft_start,
    input  logic                 fft_done,
    output logic [15:0]          frame_count,
    output logic [7:0]           drop_count
);

    localparam int             IW       = $clog2(N);
    localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   wr_idx_q, wr_idx_d;
    logic            wr_bank_q, wr_bank_d;
    logic            rd_bank_q, rd_bank_d;
    logic            fft_busy_q, fft_busy_d;
    logic            fft_start_q, fft_start_d;
    logic [15:0]     frame_count_q, frame_count_d;
    logic [7:0]      drop_count_q, drop_count_d;

    logic [WIDTH-1:0] bank0_q [N];
    logic [WIDTH-1:0] bank1_q [N];

    logic accept;
    logic fft_idle;
    logic frame_done;
    logic launch;

`ifdef FRAME_DROP_EN
    assign sample_ready = 1'b1;
`else
    assign sample_ready = (state_q == ST_FILL);
`endif

    assign accept      = sample_valid & sample_ready;
    // a done arriving in the same cycle frees the FFT for an immediate launch
    assign fft_idle    = ~fft_busy_q | fft_done;
    assign frame_done  = accept & (wr_idx_q == LAST_IDX);

    assign fft_start   = fft_start_q;
    assign frame_count = frame_count_q;
    assign drop_count  = drop_count_q;

    always_comb begin
        state_d       = state_q;
        wr_idx_d      = accept ? wr_idx_q + IW'(1) : wr_idx_q;
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        fft_busy_d    = fft_busy_q;
        fft_start_d   = 1'b0;
        frame_count_d = frame_count_q;
        drop_count_d  = drop_count_q;
        launch        = 1'b0;

        case (state_q)
            ST_FILL: begin
                if (frame_done) begin
                    if (fft_idle) begin
                        launch = 1'b1;
                    end else begin
`ifdef FRAME_DROP_EN
                        // wr_idx has wrapped to 0, so the same bank is refilled
                        if (drop_count_q != 8'hFF) begin
                            drop_count_d = drop_count_q + 8'd1;
                        end
`else
                        state_d = ST_FULL;
`endif
                    end
                end
            end
            ST_FULL: begin
                if (fft_idle) begin
                    launch  = 1'b1;
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase

        if (launch) begin
            rd_bank_d     = wr_bank_q;
            wr_bank_d     = ~wr_bank_q;
            wr_idx_d      = '0;
            fft_busy_d    = 1'b1;
            fft_start_d   = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
        end else if (fft_done) begin
            fft_busy_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_FILL;
            wr_idx_q      <= '0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b1;
            fft_busy_q    <= 1'b0;
            fft_start_q   <= 1'b0;
            frame_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            wr_idx_q      <= wr_idx_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            fft_busy_q    <= fft_busy_d;
            fft_start_q   <= fft_start_d;
            frame_count_q <= frame_count_d;
            drop_count_q  <= drop_count_d;
        end
    end

    // Only the write bank is ever written, so the bank seen by the FFT is frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                bank0_q[k] <= '0;
                bank1_q[k] <= '0;
            end
        end else if (accept) begin
            if (wr_bank_q) begin
                bank1_q[wr_idx_q] <= sample_in;
            end else begin
                bank0_q[wr_idx_q] <= sample_in;
            end
        end
    end

    generate
        for (genvar k = 0; k < N; k++) begin : g_out
            assign time_samples[k*WIDTH +: WIDTH] = rd_bank_q ? bank1_q[k] : bank0_q[k];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module : tb_fft_frame_buffer
// Desc   : Directed self-checking bench for fft_frame_buffer with a
//          frame-level reference model compared on every cycle.
// Rev    : 1.0
// ============================================================================
module tb_fft_frame_buffer;

    localparam int W = 12;
    localparam int N = 256;
`ifdef FRAME_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [W-1:0]     sample_in = '0;
    logic             sample_valid = 1'b0;
    logic             sample_ready;
    logic [N*W-1:0]   time_samples;
    logic             fft_start;
    logic             fft_done = 1'b0;
    logic [15:0]      frame_count;
    logic [7:0]       drop_count;

    fft_frame_buffer #(.WIDTH(W), .N(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .time_samples (time_samples),
        .fft_start    (fft_start),
        .fft_done     (fft_done),
        .frame_count  (frame_count),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ts(input int k);
        return time_samples[k*W +: W];
    endfunction

    // ---------------- reference model (frame level) ----------------
    logic [W-1:0]    m_q[$];
    logic [N*W-1:0]  m_shown = '0;
    logic [N*W-1:0]  m_held_v = '0;
    bit              m_held = 0;
    bit              m_busy = 0;
    bit              m_start = 0;
    int              m_fc = 0;
    int              m_dc = 0;
    bit              m_idle, m_rdy, m_launch;

    function automatic logic [N*W-1:0] pack_q();
        logic [N*W-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = m_q[k];
        return v;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_q.delete();
            m_shown = '0; m_held = 0; m_busy = 0; m_start = 0; m_fc = 0; m_dc = 0;
        end else begin
            m_idle   = !m_busy || fft_done;
            m_rdy    = DROP ? 1'b1 : !m_held;
            m_launch = 0;
            if (m_held && m_idle) begin
                m_shown  = m_held_v;
                m_held   = 0;
                m_launch = 1;
            end
            if (sample_valid && m_rdy) begin
                m_q.push_back(sample_in);
                if (m_q.size() == N) begin
                    if (m_idle) begin
                        m_shown  = pack_q();
                        m_launch = 1;
                    end else if (DROP) begin
                        m_dc = (m_dc == 255) ? 255 : m_dc + 1;
                    end else begin
                        m_held_v = pack_q();
                        m_held   = 1;
                    end
                    m_q.delete();
                end
            end
            if (m_launch) begin
                m_busy = 1;
                m_fc   = (m_fc + 1) % 65536;
            end else if (fft_done) begin
                m_busy = 0;
            end
            m_start = m_launch;
        end
    end

    // per-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("cyc_sample_ready", {31'd0, sample_ready}, {31'd0, (DROP ? 1'b1 : !m_held)});
            chk("cyc_fft_start", {31'd0, fft_start}, {31'd0, m_start});
            chk("cyc_frame_count", {16'd0, frame_count}, m_fc);
            chk("cyc_drop_count", {24'd0, drop_count}, m_dc);
            n_checks++;
            if (time_samples !== m_shown) begin
                n_fail++;
                for (int k = 0; k < N; k++) begin
                    if (time_samples[k*W +: W] !== m_shown[k*W +: W]) begin
                        $display("FAIL cyc_time_samples[%0d]: got %0h expected %0h at %0t",
                                 k, time_samples[k*W +: W], m_shown[k*W +: W], $time);
                        break;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] v, input bit with_done = 1'b0);
        int t = 0;
        while (!sample_ready && t < 50) begin
            tick();
            t++;
        end
        if (!sample_ready) begin
            chk("send_ready_timeout", {31'd0, sample_ready}, 32'd1);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $fatal(1, "sample_ready stuck low");
        end
        sample_in    = v;
        sample_valid = 1'b1;
        fft_done     = with_done;
        tick();
        sample_valid = 1'b0;
        fft_done     = 1'b0;
    endtask

    task automatic pulse_done();
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
    endtask

    initial begin
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst_frame_count", {16'd0, frame_count}, 32'd0);
        chk("rst_drop_count", {24'd0, drop_count}, 32'd0);
        chk("rst_fft_start", {31'd0, fft_start}, 32'd0);
        chk("rst_ready", {31'd0, sample_ready}, 32'd1);

        // 1: partial frame then reset mid-frame
        for (int i = 0; i < 100; i++) send(W'(1000 + i));
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_ts0", {20'd0, ts(0)}, 32'd0);
        chk("midrst_fc", {16'd0, frame_count}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // 2: one frame, value = index
        for (int i = 0; i < N; i++) send(W'(i));
        chk("t2_start_hi", {31'd0, fft_start}, 32'd1);
        chk("t2_fc", {16'd0, frame_count}, 32'd1);
        chk("t2_ts0", {20'd0, ts(0)}, 32'd0);
        chk("t2_ts99", {20'd0, ts(99)}, 32'd99);
        chk("t2_ts255", {20'd0, ts(255)}, 32'd255);
        tick();
        chk("t2_start_lo", {31'd0, fft_start}, 32'd0);

`ifndef FRAME_DROP_EN
        // 3: backpressure while FFT busy
        for (int i = 0; i < N; i++) send(W'(256 + i));
        chk("t3_ready_lo", {31'd0, sample_ready}, 32'd0);
        chk("t3_no_start", {31'd0, fft_start}, 32'd0);
        tick(); tick(); tick();
        chk("t3_ts5_held", {20'd0, ts(5)}, 32'd5);
        pulse_done();
        chk("t3_start", {31'd0, fft_start}, 32'd1);
        chk("t3_ts5", {20'd0, ts(5)}, 32'd261);
        chk("t3_ts255", {20'd0, ts(255)}, 32'd511);
        chk("t3_fc", {16'd0, frame_count}, 32'd2);

        // 4: done coincident with the last accept
        for (int i = 0; i < N - 1; i++) send(W'(12'h800 + i));
        send(12'h8FF, 1'b1);
        chk("t4_start", {31'd0, fft_start}, 32'd1);
        chk("t4_ready", {31'd0, sample_ready}, 32'd1);
        chk("t4_fc", {16'd0, frame_count}, 32'd3);
        chk("t4_ts0", {20'd0, ts(0)}, 32'h800);
        for (int i = 0; i < N; i++) send(W'(3 * i));
        chk("t4_busy_kept", {31'd0, sample_ready}, 32'd0);
        pulse_done();
        chk("t4_fc4", {16'd0, frame_count}, 32'd4);
        chk("t4_ts100", {20'd0, ts(100)}, 32'd300);
        pulse_done();
`else
        // 5: drop mode, frame completing while FFT busy is discarded
        for (int i = 0; i < N; i++) send(W'(7 * i));
        chk("t5_dc", {24'd0, drop_count}, 32'd1);
        chk("t5_ready", {31'd0, sample_ready}, 32'd1);
        chk("t5_ts1", {20'd0, ts(1)}, 32'd1);
        pulse_done();
        for (int i = 0; i < N; i++) send(W'(5 * i));
        chk("t5_start", {31'd0, fft_start}, 32'd1);
        chk("t5_fc", {16'd0, frame_count}, 32'd2);
        chk("t5_ts3", {20'd0, ts(3)}, 32'd15);
        pulse_done();
`endif
        // done while idle must be ignored
        pulse_done();
        tick();

        // 6: extreme two's-complement values pass bit-exact
        send(12'hF47);
        send(12'h7FF);
        send(12'h800);
        for (int i = 3; i < N; i++) send(W'(i));
        chk("t6_start", {31'd0, fft_start}, 32'd1);
        chk("t6_ts0", {20'd0, ts(0)}, 32'hF47);
        chk("t6_ts1", {20'd0, ts(1)}, 32'h7FF);
        chk("t6_ts2", {20'd0, ts(2)}, 32'h800);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
